// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash arbiter: FSM states, port ids and
// default bus widths.
package flash_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/flash_arbiter_if.sv
// Bundle of core-side fetch/data ports and the Mem_Flash handshake.
// The arbiter uses the slave view; the surrounding core/flash use master.
interface flash_arbiter_if
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              buf_inv;
    logic              ld_flash;
    logic [ADDR_W-1:0] flash_addr_PC;
    logic              flash_busy;
    logic [DATA_W-1:0] dout_flash;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, buf_inv, flash_busy, dout_flash,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, ld_flash, flash_addr_PC
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, buf_inv, flash_busy, dout_flash,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, ld_flash, flash_addr_PC
    );

endinterface

// File: rtl/flash_line_buf.sv
// One-entry fetch line buffer: tag/data/valid with combinational lookup,
// registered fill and invalidate. Invalidate wins over a simultaneous fill.
module flash_line_buf #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inv
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;

    // NOTE: only valid_q decides a hit; tag/data are reset as well so the
    // buffer never presents X on its data output after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            if (fill_en) begin
                tag_q  <= fill_tag;
                data_q <= fill_data;
            end
            if (inv) begin
                valid_q <= 1'b0;
            end else if (fill_en) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign hit      = valid_q && (tag_q == lookup_addr);
    assign hit_data = data_q;

endmodule

// File: rtl/flash_arbiter.sv
// Arbitrates the single-ported flash between instruction fetch and data load,
// with bounded data priority, a one-entry fetch buffer and a busy timeout.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT     = 64,
    parameter int DATA_STREAK = 2
) (
    input  logic           clk,
    input  logic           rst,
    flash_arbiter_if.slave bus
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int STK_W = $clog2(DATA_STREAK + 1);

    localparam logic [TMR_W-1:0] TIMEOUT_V = TMR_W'(TIMEOUT);
    localparam logic [STK_W-1:0] STREAK_V  = STK_W'(DATA_STREAK);

    state_t            state_q, state_d;
    logic              ld_q, ld_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              port_q, port_d;
    logic [STK_W-1:0]  streak_q, streak_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              seen_q, seen_d;

    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;
    logic              fill_en;
    logic              d_wins;

    flash_line_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (bus.if_addr),
        .hit         (buf_hit),
        .hit_data    (buf_data),
        .fill_en     (fill_en),
        .fill_tag    (addr_q),
        .fill_data   (bus.dout_flash),
        .inv         (bus.buf_inv)
    );

    // Data keeps priority until it has won DATA_STREAK grants over a waiting fetch.
    assign d_wins = bus.d_req && ((streak_q < STREAK_V) || !bus.if_req);

    // NOTE: every signal gets its default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        ld_d     = 1'b0;
        if_ack_d = 1'b0;
        d_ack_d  = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        addr_d   = addr_q;
        port_d   = port_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        seen_d   = seen_q;
        fill_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_wins) begin
                    port_d  = PORT_D;
                    addr_d  = bus.d_addr;
                    state_d = ISSUE;
                    ld_d    = !bus.flash_busy;
                    if (streak_q != STREAK_V) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (bus.if_req) begin
                    port_d   = PORT_IF;
                    streak_d = '0;
                    if (buf_hit) begin
                        state_d  = RESP;
                        if_ack_d = 1'b1;
                        rdata_d  = buf_data;
                        err_d    = 1'b0;
                    end else begin
                        addr_d  = bus.if_addr;
                        state_d = ISSUE;
                        ld_d    = !bus.flash_busy;
                    end
                end
            end

            // The strobe is registered, so ISSUE lasts until the cycle it is visible.
            ISSUE: begin
                if (ld_q) begin
                    state_d = WAIT;
                    timer_d = '0;
                    seen_d  = 1'b0;
                end else if (!bus.flash_busy) begin
                    ld_d = 1'b1;
                end
            end

            WAIT: begin
                seen_d = seen_q || bus.flash_busy;
                if (seen_q && !bus.flash_busy) begin
                    state_d  = RESP;
                    rdata_d  = bus.dout_flash;
                    err_d    = 1'b0;
                    if_ack_d = (port_q == PORT_IF);
                    d_ack_d  = (port_q == PORT_D);
                    fill_en  = (port_q == PORT_IF);
                end else if (timer_q == TIMEOUT_V) begin
                    state_d  = RESP;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    if_ack_d = (port_q == PORT_IF);
                    d_ack_d  = (port_q == PORT_D);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ld_q     <= 1'b0;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            port_q   <= PORT_IF;
            streak_q <= '0;
            timer_q  <= '0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_q     <= ld_d;
            if_ack_q <= if_ack_d;
            d_ack_q  <= d_ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            port_q   <= port_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            seen_q   <= seen_d;
        end
    end

    assign bus.if_ack        = if_ack_q;
    assign bus.if_rdata      = rdata_q;
    assign bus.if_err        = err_q;
    assign bus.d_ack         = d_ack_q;
    assign bus.d_rdata       = rdata_q;
    assign bus.d_err         = err_q;
    assign bus.ld_flash      = ld_q;
    assign bus.flash_addr_PC = addr_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Randomized self-checking bench for flash_arbiter: a transaction-level model
// predicts grant order, buffer hits, data, error flag and ack/strobe cycles.
module tb_flash_arbiter;
    import flash_arb_pkg::*;

    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int TIMEOUT = 64;
    localparam int STREAK  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flash_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    flash_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT     (TIMEOUT),
        .DATA_STREAK (STREAK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash environment: word memory plus knobs set by the stimulus.
    logic [DW-1:0] mem [1 << AW];
    int cyc = 0;
    int lat_cfg = 2;
    bit stuck_cfg = 1'b0;
    int ext_until = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    bit            m_valid;
    logic [AW-1:0] m_tag;
    logic [DW-1:0] m_data;
    int            m_streak;

    function automatic logic pick(input bit if_p, input bit d_p);
        return (d_p && (m_streak < STREAK || !if_p)) ? PORT_D : PORT_IF;
    endfunction

    task automatic model_txn(input logic port, input logic [AW-1:0] addr, input bit stuck,
                             output bit hit, output logic [DW-1:0] data, output bit err);
        hit = (port == PORT_IF) && m_valid && (m_tag == addr);
        if (port == PORT_D) m_streak = (m_streak < STREAK) ? m_streak + 1 : STREAK;
        else                m_streak = 0;
        if (hit) begin
            data = m_data;
            err  = 1'b0;
        end else if (stuck) begin
            data = '0;
            err  = 1'b1;
        end else begin
            data = mem[addr];
            err  = 1'b0;
            if (port == PORT_IF) begin
                m_valid = 1'b1;
                m_tag   = addr;
                m_data  = data;
            end
        end
    endtask

    // Flash responder: busy for lat_cfg cycles after each strobe (or forever when stuck).
    initial begin
        int busy_left = 0;
        bit stuck_on  = 1'b0;
        bit prev_ld   = 1'b0;
        bus.flash_busy = 1'b0;
        bus.dout_flash = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                busy_left      = 0;
                stuck_on       = 1'b0;
                prev_ld        = 1'b0;
                bus.flash_busy = 1'b0;
            end else begin
                if (!stuck_cfg) stuck_on = 1'b0;
                bus.flash_busy = (busy_left > 0) || stuck_on || (cyc < ext_until);
                if (busy_left > 0) busy_left--;
                if (bus.ld_flash) begin
                    check("ld_while_busy", 64'(bus.flash_busy), 64'(0));
                    check("ld_back_to_back", 64'(prev_ld), 64'(0));
                    bus.dout_flash = mem[bus.flash_addr_PC];
                    if (stuck_cfg) stuck_on = 1'b1;
                    else           busy_left = lat_cfg;
                end
                prev_ld = bus.ld_flash;
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        check({tag, ".ctrl"}, 64'({bus.if_ack, bus.d_ack, bus.if_err, bus.d_err, bus.ld_flash}), 64'(0));
        check({tag, ".if_rdata"}, 64'(bus.if_rdata), 64'(0));
        check({tag, ".d_rdata"}, 64'(bus.d_rdata), 64'(0));
        check({tag, ".flash_addr"}, 64'(bus.flash_addr_PC), 64'(0));
    endtask

    // One request on one port; pre_busy = cycles flash is busy from cycle 0.
    task automatic run_txn(input logic port, input logic [AW-1:0] addr, input int lat,
                           input int pre_busy, input bit stuck, input string tag);
        bit            hit;
        bit            e_err;
        logic [DW-1:0] e_data;
        logic [DW-1:0] g_data = 'x;
        logic          g_err = 1'bx;
        int            e_ld, e_ack;
        int            ld_cnt = 0, ld_at = -1, ack_at = -1, stray = 0;
        model_txn(port, addr, stuck, hit, e_data, e_err);
        e_ld  = hit ? -1 : ((pre_busy > 0) ? pre_busy + 1 : 1);
        e_ack = hit ? 1 : e_ld + 2 + (stuck ? TIMEOUT : lat);

        @(posedge clk);
        #1;
        lat_cfg   = lat;
        stuck_cfg = stuck;
        ext_until = cyc + pre_busy;
        if (port == PORT_IF) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.d_req  = 1'b1;
            bus.d_addr = addr;
        end
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (bus.ld_flash) begin
                ld_cnt++;
                ld_at = k;
            end
            if ((port == PORT_IF) ? bus.d_ack : bus.if_ack) stray++;
            if ((port == PORT_IF) ? bus.if_ack : bus.d_ack) begin
                ack_at = k;
                g_data = (port == PORT_IF) ? bus.if_rdata : bus.d_rdata;
                g_err  = (port == PORT_IF) ? bus.if_err : bus.d_err;
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
                break;
            end
        end
        stuck_cfg = 1'b0;
        check({tag, ".ack_cycle"}, 64'(ack_at), 64'(e_ack));
        check({tag, ".rdata"}, 64'(g_data), 64'(e_data));
        check({tag, ".err"}, 64'(g_err), 64'(e_err));
        check({tag, ".ld_count"}, 64'(ld_cnt), hit ? 64'(0) : 64'(1));
        check({tag, ".ld_cycle"}, 64'(ld_at), 64'(e_ld));
        check({tag, ".other_ack"}, 64'(stray), 64'(0));
    endtask

    task automatic pulse_inv();
        @(posedge clk);
        #1;
        bus.buf_inv = 1'b1;
        @(posedge clk);
        #1;
        bus.buf_inv = 1'b0;
        m_valid = 1'b0;
    endtask

    initial begin
        logic          exp_port [6];
        logic [DW-1:0] exp_data [6];
        bit            hit, e_err;
        logic [DW-1:0] d;
        int            n, stray;
        logic          p;

        rst         = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_addr  = '0;
        bus.buf_inv = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom();
        mem[10'h010] = 32'hDEADBEEF;
        m_valid  = 1'b0;
        m_tag    = '0;
        m_data   = '0;
        m_streak = 0;

        #12;
        check_reset_outs("reset");
        @(posedge clk);
        #3;
        rst = 1'b0;

        // Miss, hit, then invalidate and miss again.
        run_txn(PORT_IF, 10'h010, 3, 0, 1'b0, "fetch_miss");
        run_txn(PORT_IF, 10'h010, 3, 0, 1'b0, "fetch_hit");
        pulse_inv();
        run_txn(PORT_IF, 10'h010, 3, 0, 1'b0, "fetch_after_inv");

        // Both ports held: bounded data priority.
        for (int g = 0; g < 6; g++) begin
            p = pick(1'b1, 1'b1);
            model_txn(p, (p == PORT_D) ? 10'h040 : 10'h030, 1'b0, hit, d, e_err);
            exp_port[g] = p;
            exp_data[g] = d;
        end
        @(posedge clk);
        #1;
        lat_cfg     = 2;
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h030;
        bus.d_req   = 1'b1;
        bus.d_addr  = 10'h040;
        n = 0;
        for (int k = 0; k < 400 && n < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.if_ack || bus.d_ack) begin
                check("arb_both_ack", 64'(bus.if_ack & bus.d_ack), 64'(0));
                check($sformatf("arb_order%0d", n), 64'(bus.d_ack), 64'(exp_port[n]));
                check($sformatf("arb_data%0d", n), 64'(bus.d_ack ? bus.d_rdata : bus.if_rdata),
                      64'(exp_data[n]));
                n++;
                if (n == 6) begin
                    bus.if_req = 1'b0;
                    bus.d_req  = 1'b0;
                end
            end
        end
        check("arb_grants", 64'(n), 64'(6));
        run_txn(PORT_IF, 10'h040, 2, 0, 1'b0, "fetch_after_data");

        // Stuck busy, then normal service; busy already high at request.
        run_txn(PORT_D, 10'h123, 0, 0, 1'b1, "timeout");
        run_txn(PORT_D, 10'h124, 2, 0, 1'b0, "after_timeout");
        run_txn(PORT_IF, 10'h200, 2, 4, 1'b0, "busy_first");

        // Asynchronous reset while waiting on flash.
        run_txn(PORT_IF, 10'h055, 1, 0, 1'b0, "pre_reset");
        @(posedge clk);
        #1;
        stuck_cfg   = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h077;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outs("async_rst");
        bus.if_req = 1'b0;
        stuck_cfg  = 1'b0;
        m_valid    = 1'b0;
        m_streak   = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        stray = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            stray += int'(bus.if_ack | bus.d_ack | bus.ld_flash);
        end
        check("no_ack_after_rst", 64'(stray), 64'(0));
        run_txn(PORT_IF, 10'h055, 2, 0, 1'b0, "post_reset_miss");

        // Random single-port traffic over a few addresses.
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a;
            int            pb;
            a  = 10'h010 + AW'($urandom_range(0, 3));
            pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 5) == 0) pulse_inv();
            run_txn(logic'($urandom_range(0, 1)), a, int'($urandom_range(1, 4)), pb, 1'b0,
                    $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

Shares the single-ported flash region (Mem_Flash) between the core's instruction-fetch port and data-load port. It arbitrates with bounded data priority and drives the flash load/busy handshake. It keeps a one-entry fetch buffer so repeated fetches of the same word skip the flash, and it enforces a busy timeout. It sits inside Mem, between the core-side ports and Mem_Flash.

## Interface
- ADDR_W, 10, flash word-address width
- DATA_W, 32, flash data width
- TIMEOUT, 64, max cycles from ld_flash to completion before error
- DATA_STREAK, 2, max consecutive data grants while fetch is pending
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch word address, stable while if_req
- if_ack  out  1  one-cycle fetch completion
- if_rdata  out  DATA_W  fetch data, valid with if_ack
- if_err  out  1  fetch timed out, valid with if_ack
- d_req, d_addr, d_ack, d_rdata, d_err  same directions/widths/meaning for the data port
- buf_inv  in  1  invalidate fetch buffer
- ld_flash  out  1  one-cycle flash load strobe
- flash_addr_PC  out  ADDR_W  flash address, held from ld_flash until completion
- flash_busy  in  1  flash busy
- dout_flash  in  DATA_W  flash read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Data wins if d_req and (streak < DATA_STREAK or !if_req). Otherwise fetch wins if if_req.
  - The winner's address and port id are latched at grant.
- Streak counter:
  - +1 on each data grant, saturating at DATA_STREAK.
  - Cleared on each fetch grant, including buffer hits.
- Fetch buffer hit (valid and tag == if_addr on a fetch grant): IDLE -> RESP with buffer data. No flash access.
- Otherwise IDLE -> ISSUE.
- ISSUE: wait while flash_busy=1. When flash_busy=0, pulse ld_flash for exactly one cycle, clear the timeout counter, and go to WAIT.
- WAIT: the timeout counter counts up each cycle.
  - Completion is the first cycle with flash_busy=0 after flash_busy has been seen high. dout_flash is captured in that cycle -> RESP.
  - If the counter reaches TIMEOUT first: rdata=0, err=1 -> RESP.
- RESP: assert the winner's ack (plus rdata and err) for one cycle -> IDLE.
  - A req still high in the following IDLE cycle is a new request.
- Buffer fill: only on a successful fetch completion from flash (tag and data). Data-port reads and errors never fill it.
- buf_inv clears valid in any state. When buf_inv coincides with a fill, the result is invalid.
- Non-winning port: its ack stays 0, and its rdata/err are don't-care except while its ack is high.
- Reset (async, any state): state=IDLE; ld_flash=0; if_ack=d_ack=0; if_err=d_err=0; rdata=0; flash_addr_PC=0; streak=0; buffer invalid. No ack is issued for an aborted transaction.

## Timing
- Cycle 0 = first IDLE cycle with req high.
- Buffer hit: ack in cycle 1.
- Miss with flash idle:
  - ld_flash in cycle 1.
  - WAIT from cycle 2.
  - If flash_busy is high for cycles 2..1+L and low in cycle 2+L: capture in 2+L, ack in 3+L.
- ld_flash is never asserted while flash_busy=1 and never for two consecutive cycles.
- Timeout: err ack in cycle 2+TIMEOUT+1 after a cycle-1 ld_flash.
- All outputs are registered. There is no combinational path from req to ack or ld_flash.

## Structure
- Package flash_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - port-id constants PORT_IF=0, PORT_D=1
  - ADDR_W/DATA_W defaults
- Sub-module flash_line_buf: one-entry tag/data/valid register with lookup, fill and invalidate (buf_inv priority over fill).
- Top module: FSM, streak counter, timeout counter (width clog2(TIMEOUT+1)), output registers.

## Test plan
- Single fetch, addr 0x010, flash busy for 3 cycles returning 0xDEADBEEF -> ld_flash in cycle 1, if_ack with 0xDEADBEEF in cycle 6, if_err=0.
- Repeat the fetch of 0x010 -> if_ack in cycle 1 with 0xDEADBEEF and no ld_flash. Assert buf_inv, fetch again -> flash accessed.
- if_req and d_req held continuously, DATA_STREAK=2 -> grant order D, D, IF, D, D, IF. Data reads never fill the buffer.
- flash_busy stuck high after ld_flash, TIMEOUT=64 -> d_ack with d_err=1 and d_rdata=0 at cycle 67; the next request is serviced normally.
- flash_busy=1 when a request arrives -> FSM stays in ISSUE with ld_flash=0 until busy drops, then a single-cycle ld_flash.
- rst asserted in WAIT mid-transaction -> all outputs 0 immediately (asynchronous), no ack, buffer invalid. A fetch after reset release misses the buffer.
